// File: rtl/conv33_frame_sched.sv
// Frame scheduler for the 3x3 convolution datapath: buffers raster rows in four rotating
// line buffers, replays each completed 3-row band gap-free and tags the datapath output.
module conv33_frame_sched #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 48,
   parameter int CONV_LAT    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_start,
   input  logic [1:0]             cfg_mode,
   output logic                   busy,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [PIXEL_WIDTH-1:0] s_data,
   output logic [1:0]             conv_mode,
   output logic [PIXEL_WIDTH-1:0] pix_top,
   output logic [PIXEL_WIDTH-1:0] pix_mid,
   output logic [PIXEL_WIDTH-1:0] pix_bot,
   input  logic [PIXEL_WIDTH-1:0] conv_pixel,
   output logic                   m_valid,
   output logic [PIXEL_WIDTH-1:0] m_data,
   output logic                   m_last,
   output logic                   frame_done
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int DW = $clog2(CONV_LAT + 2) + 1;
   localparam logic [XW-1:0] X_MAX     = XW'(IMG_W - 1);
   localparam logic [XW-1:0] X_FIRST   = XW'(2);
   localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H - 1);
   localparam logic [YW-1:0] Y_BAND    = YW'(2);
   localparam logic [DW-1:0] DRAIN_MAX = DW'(CONV_LAT);
   localparam logic [PIXEL_WIDTH-1:0] PIX_ZERO = {PIXEL_WIDTH{1'b0}};

   typedef enum logic [1:0] {F_IDLE = 2'd0, F_RUN = 2'd1, F_DONE = 2'd2} fstate_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_SWEEP = 2'd1, S_DRAIN = 2'd2} sstate_t;

   fstate_t f_state_r, f_next_s;
   sstate_t s_state_r, s_next_s;

   logic [PIXEL_WIDTH-1:0] line_buf [0:3][0:IMG_W-1];

   logic [XW-1:0] in_x_r;
   logic [YW-1:0] in_y_r;
   logic [1:0]    wbuf_r;
   logic          in_done_r;
   logic          pend_r;
   logic [1:0]    pend_buf_r;
   logic          pend_final_r;
   logic [XW-1:0] sx_r;
   logic [DW-1:0] drain_r;
   logic [1:0]    bot_buf_r;
   logic          sweep_final_r;
   logic [1:0]    mid_buf_s;
   logic [1:0]    top_buf_s;

   logic [CONV_LAT:0] tag_v_r;
   logic [CONV_LAT:0] tag_l_r;
   logic [CONV_LAT:0] tag_f_r;

   logic [1:0]             conv_mode_r;
   logic                   busy_r;
   logic                   frame_done_r;
   logic [PIXEL_WIDTH-1:0] pix_top_r;
   logic [PIXEL_WIDTH-1:0] pix_mid_r;
   logic [PIXEL_WIDTH-1:0] pix_bot_r;
   logic                   m_valid_r;
   logic [PIXEL_WIDTH-1:0] m_data_r;
   logic                   m_last_r;
   logic                   m_final_r;

   logic start_s;
   logic xfer_s;
   logic row_done_s;
   logic issue_s;
   logic sweep_go_s;
   logic last_out_s;

   assign start_s    = (f_state_r == F_IDLE) & cfg_start;
   assign s_ready    = (f_state_r == F_RUN) & ~in_done_r & ~pend_r;
   assign xfer_s     = s_valid & s_ready;
   assign row_done_s = xfer_s & (in_x_r == X_MAX);
   assign issue_s    = (s_state_r == S_SWEEP);
   assign sweep_go_s = (s_state_r != S_SWEEP) & (s_next_s == S_SWEEP);
   assign last_out_s = m_valid_r & m_last_r & m_final_r;
   // Band rows r-2 and r-1 sit in the two buffers written before row r's buffer.
   assign mid_buf_s  = bot_buf_r - 2'd1;
   assign top_buf_s  = bot_buf_r - 2'd2;

   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign conv_mode  = conv_mode_r;
   assign pix_top    = pix_top_r;
   assign pix_mid    = pix_mid_r;
   assign pix_bot    = pix_bot_r;
   assign m_valid    = m_valid_r;
   assign m_data     = m_data_r;
   assign m_last     = m_last_r;

   // Frame FSM next state.
   always_comb begin
      f_next_s = f_state_r;
      case (f_state_r)
         F_IDLE:  if (cfg_start) f_next_s = F_RUN;  else f_next_s = F_IDLE;
         F_RUN:   if (last_out_s) f_next_s = F_DONE; else f_next_s = F_RUN;
         F_DONE:  f_next_s = F_IDLE;
         default: f_next_s = F_IDLE;
      endcase
   end

   // Frame state, mode latch and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_state_r    <= F_IDLE;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         conv_mode_r  <= 2'd0;
      end else begin
         f_state_r    <= f_next_s;
         busy_r       <= (f_next_s != F_IDLE);
         frame_done_r <= (f_next_s == F_DONE);
         if (start_s) conv_mode_r <= cfg_mode;
      end
   end

   // Input writer: raster position, buffer rotation and sweep request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_x_r       <= {XW{1'b0}};
         in_y_r       <= {YW{1'b0}};
         wbuf_r       <= 2'd0;
         in_done_r    <= 1'b0;
         pend_r       <= 1'b0;
         pend_buf_r   <= 2'd0;
         pend_final_r <= 1'b0;
      end else if (start_s) begin
         in_x_r       <= {XW{1'b0}};
         in_y_r       <= {YW{1'b0}};
         wbuf_r       <= 2'd0;
         in_done_r    <= 1'b0;
         pend_r       <= 1'b0;
         pend_buf_r   <= 2'd0;
         pend_final_r <= 1'b0;
      end else if (row_done_s) begin
         in_x_r <= {XW{1'b0}};
         wbuf_r <= wbuf_r + 2'd1;
         if (in_y_r == Y_MAX) in_done_r <= 1'b1;
         else                 in_y_r    <= in_y_r + YW'(1);
         if (in_y_r >= Y_BAND) begin
            pend_r       <= 1'b1;
            pend_buf_r   <= wbuf_r;
            pend_final_r <= (in_y_r == Y_MAX);
         end
      end else if (xfer_s) begin
         in_x_r <= in_x_r + XW'(1);
      end else if (sweep_go_s) begin
         pend_r <= 1'b0;
      end
   end

   // Line buffer storage.
   always_ff @(posedge clk) begin
      if (xfer_s) line_buf[wbuf_r][in_x_r] <= s_data;
   end

   // Sweep FSM next state.
   always_comb begin
      s_next_s = s_state_r;
      case (s_state_r)
         S_IDLE:  if (pend_r) s_next_s = S_SWEEP; else s_next_s = S_IDLE;
         S_SWEEP: if (sx_r == X_MAX) s_next_s = S_DRAIN; else s_next_s = S_SWEEP;
         S_DRAIN: begin
            if (drain_r == DRAIN_MAX) begin
               if (pend_r) s_next_s = S_SWEEP;
               else        s_next_s = S_IDLE;
            end else begin
               s_next_s = S_DRAIN;
            end
         end
         default: s_next_s = S_IDLE;
      endcase
   end

   // Sweep state, column counter and band selection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_state_r     <= S_IDLE;
         sx_r          <= {XW{1'b0}};
         drain_r       <= {DW{1'b0}};
         bot_buf_r     <= 2'd0;
         sweep_final_r <= 1'b0;
      end else begin
         s_state_r <= s_next_s;
         drain_r   <= (s_state_r == S_DRAIN) ? drain_r + DW'(1) : {DW{1'b0}};
         if (sweep_go_s) begin
            sx_r          <= {XW{1'b0}};
            bot_buf_r     <= pend_buf_r;
            sweep_final_r <= pend_final_r;
         end else if (issue_s) begin
            sx_r <= sx_r + XW'(1);
         end
      end
   end

   // Synchronous column read; zero whenever no column was issued.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_top_r <= PIX_ZERO;
         pix_mid_r <= PIX_ZERO;
         pix_bot_r <= PIX_ZERO;
      end else if (issue_s) begin
         pix_top_r <= line_buf[top_buf_s][sx_r];
         pix_mid_r <= line_buf[mid_buf_s][sx_r];
         pix_bot_r <= line_buf[bot_buf_r][sx_r];
      end else begin
         pix_top_r <= PIX_ZERO;
         pix_mid_r <= PIX_ZERO;
         pix_bot_r <= PIX_ZERO;
      end
   end

   // Tag delay line matching read latency plus datapath latency, then the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v_r   <= {(CONV_LAT+1){1'b0}};
         tag_l_r   <= {(CONV_LAT+1){1'b0}};
         tag_f_r   <= {(CONV_LAT+1){1'b0}};
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         m_final_r <= 1'b0;
         m_data_r  <= PIX_ZERO;
      end else begin
         for (int i = CONV_LAT; i > 0; i--) begin
            tag_v_r[i] <= tag_v_r[i-1];
            tag_l_r[i] <= tag_l_r[i-1];
            tag_f_r[i] <= tag_f_r[i-1];
         end
         tag_v_r[0] <= issue_s & (sx_r >= X_FIRST);
         tag_l_r[0] <= issue_s & (sx_r == X_MAX);
         tag_f_r[0] <= issue_s & sweep_final_r;
         m_valid_r  <= tag_v_r[CONV_LAT];
         m_last_r   <= tag_v_r[CONV_LAT] & tag_l_r[CONV_LAT];
         m_final_r  <= tag_v_r[CONV_LAT] & tag_f_r[CONV_LAT];
         m_data_r   <= tag_v_r[CONV_LAT] ? conv_pixel : PIX_ZERO;
      end
   end

endmodule

// File: doc/conv33_frame_sched.md
Name: conv33_frame_sched

Overview:
- Frame-level scheduler that sequences the 3x3 convolution datapath.
- Accepts a raster pixel stream over a valid/ready handshake and buffers rows in four rotating line buffers.
- The convolution window advances every clock with no enable, so the scheduler replays each completed 3-row band gap-free, one column per cycle.
- Tags the datapath's output with valid, row-end and frame-end markers; output image is (IMG_W-2)x(IMG_H-2), interior pixels only.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel; must match the datapath.
- IMG_W, 64, image width in pixels; minimum 3.
- IMG_H, 48, image height in rows; minimum 3.
- CONV_LAT, 1, cycles from pix_* presented to the datapath until its pixel_out holds that column's result.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse; starts a frame when idle.
- cfg_mode  in  2  kernel select (0 sharpen, 1 gaussian, 2 edge, 3 pass-through); sampled on an accepted cfg_start.
- busy  out  1  high from accepted start until frame_done.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  scheduler can accept a pixel.
- s_data  in  PIXEL_WIDTH  input pixel, raster order.
- conv_mode  out  2  mode to datapath; latched, constant for the whole frame.
- pix_top, pix_mid, pix_bot  out  PIXEL_WIDTH each  column feed to datapath (rows r-2, r-1, r).
- conv_pixel  in  PIXEL_WIDTH  datapath pixel_out.
- m_valid  out  1  output pixel valid; no backpressure.
- m_data  out  PIXEL_WIDTH  output pixel (registered copy of conv_pixel).
- m_last  out  1  with m_valid: last pixel of an output row.
- frame_done  out  1  one-cycle pulse after the final output pixel.

Behaviour:
- Reset: all outputs 0, counters 0, FSMs idle, line-buffer write pointer to buffer 0. Reset mid-frame aborts: no further m_valid, input stream must restart.
- Frame FSM:
  - F_IDLE: cfg_start moves to F_RUN, latches cfg_mode to conv_mode, clears counters, busy=1.
  - F_RUN: persists until the last output pixel is emitted.
  - F_DONE: one cycle, frame_done=1, busy drops next cycle, returns to F_IDLE.
  - cfg_start is ignored outside F_IDLE.
- Input writer, active in F_RUN:
  - Transfer when s_valid & s_ready. Pixel goes to buffer wbuf at column in_x; in_x wraps at IMG_W-1, then in_y++ and wbuf rotates mod 4.
  - s_ready=0 in F_IDLE/F_DONE, after IMG_W*IMG_H pixels are accepted, and while sweep_pending=1.
- Sweep FSM (S_IDLE, S_SWEEP, S_DRAIN):
  - Completing row r with r>=2 sets sweep_pending.
  - S_IDLE with pending: clear pending, select the three buffers for rows r-2/r-1/r, go S_SWEEP.
  - S_SWEEP: issues read column sx=0..IMG_W-1 on consecutive cycles with no gaps. Buffer read is synchronous, so pix_* reflect column sx one cycle after issue.
  - After sx=IMG_W-1, go S_DRAIN for 1+CONV_LAT cycles, then S_IDLE (or straight to S_SWEEP if pending).
  - The fourth buffer is the only one writable during a sweep. A row completing during a sweep sets pending and stalls input; there is no buffer overrun.
  - Outside S_SWEEP, pix_* hold 0.
- Output tagging:
  - Columns sx>=2 are interior. Their tag travels a 1+CONV_LAT+1 stage delay line, the final stage being the m_data register; m_valid asserts with m_data=conv_pixel.
  - m_last marks sx=IMG_W-1.
  - Final output is the IMG_W-1 column of the row IMG_H-1 sweep; F_DONE is entered the cycle after it.
  - Outputs per frame: (IMG_W-2)*(IMG_H-2). Each row is a contiguous m_valid burst of IMG_W-2 cycles.
- Simultaneous events:
  - Row completion in the same cycle the sweep returns to S_IDLE: the new sweep starts next cycle.
  - cfg_start the same cycle as frame_done: ignored.

Test Plan:
- IMG_W=8, IMG_H=5, mode 1, constant pixel 100, s_valid always 1 -> 18 outputs all 100, m_last on every 6th, frame_done once, busy low after.
- Same image, mode 0 -> all 100. Mode 2 -> all 0. Mode 3 -> all 100 (pass-through). conv_mode is constant across each frame.
- Mode 2, all zero except pixel (x=2,y=2)=10 -> output (0,0) is 0 (saturated -10), output (1,1) is 80, all other outputs 0.
- Random s_valid gaps (~50% duty) with a ramp image -> output sequence bit-identical to the gap-free run; each output row is a contiguous 6-cycle burst.
- Row completes while a sweep is active -> s_ready drops until the sweep starts; no pixel lost; output count is 18.
- rst_n low mid-frame -> all outputs 0 immediately. cfg_start while busy is ignored. A new frame after reset produces the correct 18 outputs.
